gc_poll_scheduler: RTL
======================

Name: gc_poll_scheduler

Overview:
Sequences the GameCube controller interface block. It issues the one-cycle Poll strobe on a fixed period or on demand, and shares the controller between NREQ requesters using round-robin arbitration. After each transaction it captures the decoded 64-bit report into a stable snapshot and drives a valid strobe. It sits between the 1 MHz-domain interface block and game/debug consumers. It also holds Rumble stable across each transaction.

Parameters:
NREQ, 2, number of on-demand requesters (1..8)
PERIOD_US, 16667, auto-poll period in usClock cycles (60 Hz)
XFER_US, 400, cycles from Poll strobe until the interface's report outputs are final
GAP_US, 200, minimum idle cycles between transactions
CW, 16, width of period/xfer/gap counters; all three parameters must be < 2^CW

Ports:
usClock  in  1  1 MHz clock
Reset  in  1  synchronous, active-high reset
enable  in  1  1 = auto-polling and request servicing allowed
req  in  NREQ  level request per requester; hold until ack
rumble_req  in  NREQ  per-requester rumble demand
ack  out  NREQ  one-cycle pulse to the requester served, coincident with snap_valid
Poll  out  1  one-cycle start strobe to the interface block
Rumble  out  1  rumble level to the interface block
rpt_in  in  64  concatenated report {status/buttons[15:0], joyX, joyY, cstickX, cstickY, lButton, rButton}
snapshot  out  64  last captured report
snap_valid  out  1  one-cycle pulse when snapshot updates
snap_changed  out  1  qualified by snap_valid; 1 if the new snapshot differs from the previous one
busy  out  1  1 in ISSUE, XFER, CAPTURE, GAP
overrun_cnt  out  8  saturating count of auto ticks lost

Behaviour:
- Reset: state IDLE; Poll, Rumble, ack, snap_valid, snap_changed, busy = 0; snapshot = 0; overrun_cnt = 0; period counter = 0; pending_auto = 0; RR pointer = NREQ-1, so req[0] wins first.
- Period counter: free-running, independent of state and enable. It counts 0..PERIOD_US-1; at PERIOD_US-1 it wraps and generates tick.
- tick with enable=1 sets pending_auto. If pending_auto is already 1, overrun_cnt increments and saturates at 255.
- tick with enable=0 is ignored.
- States: IDLE, ISSUE, XFER, CAPTURE, GAP.
- IDLE: if enable and (pending_auto or |req), go to ISSUE next cycle. Otherwise stay.
- Entering ISSUE:
  - Latch owner = RR pick among req; owner may be none if the poll is auto-only.
  - Clear pending_auto.
  - Latch Rumble = |rumble_req; Rumble then holds until the next ISSUE.
- ISSUE: Poll = 1 for exactly this cycle. Next state XFER, counter = 0.
- XFER: counts to XFER_US-1, then CAPTURE. Poll-to-capture latency = XFER_US+1 cycles.
- CAPTURE (one cycle):
  - snapshot <= rpt_in; snap_valid = 1; snap_changed = (rpt_in != previous snapshot).
  - The first capture after reset compares against 0.
  - ack[owner] = 1 if an owner exists; RR pointer <= owner.
  - Next state GAP.
- GAP: counts to GAP_US-1, then IDLE. Issue-to-issue minimum = XFER_US+GAP_US+2 cycles.
- Simultaneous tick and req: a single transaction serves both. pending_auto clears and the requester is acked.
- tick during XFER/GAP sets pending_auto, which is serviced after GAP. No transaction is ever dropped or aborted.
- req deasserted before its ack: if already the owner, it still gets ack. If not yet picked, it is simply not served.
- enable falling mid-transaction: the current transaction completes and captures. No new ISSUE until enable=1.
- Reset at any state: next cycle is the reset state. Poll is never asserted in the cycle after Reset.
- The RR arbiter considers req only at IDLE→ISSUE. The granted requester's pointer moves to it, so the next search starts at owner+1 mod NREQ.

Decomposition:
- gc_ctrl_pkg holds:
  - state enum sched_state_t {IDLE, ISSUE, XFER, CAPTURE, GAP};
  - default timing constants (PERIOD_60HZ_US = 16667, XFER_DEFAULT_US = 400, GAP_DEFAULT_US = 200);
  - report field offset constants matching the rpt_in layout.
- Sub-module gc_rr_arbiter (NREQ param): inputs req, ptr; outputs one-hot grant, any, grant index. Purely combinational, instantiated once.

Test Plan:
- Auto only: enable=1, no req, PERIOD_US=1000, XFER_US=400, GAP_US=200 → first Poll at cycle 1001 after reset release. snap_valid follows 401 cycles later with snapshot = driven rpt_in. Subsequent Poll every 1000 cycles. ack stays 0.
- RR fairness: req=2'b11 held and re-asserted after each ack → acks alternate 01,10,01,10. Consecutive Poll strobes are spaced exactly 602 cycles apart.
- Rumble latch: rumble_req[1] rises 10 cycles after a Poll → Rumble stays 0 until the next ISSUE, then reads 1 and holds through that XFER.
- Overrun: PERIOD_US=300 with XFER_US=400 → overrun_cnt increments each lost tick. Force long run → saturates at 255 and does not wrap.
- Change detect: same rpt_in (64'h0080_8080_8080_0000) twice → snap_changed=0 on the second capture. Flip the A bit → snap_changed=1.
- Reset mid-XFER: assert Reset 100 cycles after Poll → busy=0 and snapshot=0 next cycle, no snap_valid from the aborted transaction, first Poll after release at the PERIOD_US boundary.

Source files
------------

// File: rtl/gc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gc_ctrl_pkg
// Shared types and constants for the GameCube controller poll scheduler.
//   - sched_state_t : transaction sequencer states
//   - default timing constants in 1 MHz (usClock) cycles
//   - bit offsets of each field inside the 64-bit concatenated report
//   - idx_width()   : index width for an N-entry one-hot vector (min 1)
// -----------------------------------------------------------------------------
package gc_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      XFER    = 3'd2,
      CAPTURE = 3'd3,
      GAP     = 3'd4
   } sched_state_t;

   localparam int PERIOD_60HZ_US  = 16667;
   localparam int XFER_DEFAULT_US = 400;
   localparam int GAP_DEFAULT_US  = 200;

   // Report layout: {status/buttons[15:0], joyX, joyY, cstickX, cstickY, lButton, rButton}
   localparam int RPT_STATUS_LSB = 48;
   localparam int RPT_JOYX_LSB   = 40;
   localparam int RPT_JOYY_LSB   = 32;
   localparam int RPT_CX_LSB     = 24;
   localparam int RPT_CY_LSB     = 16;
   localparam int RPT_L_LSB      = 8;
   localparam int RPT_R_LSB      = 0;
   // A button: bit 0 of the first (upper) status byte
   localparam int RPT_A_BIT      = RPT_STATUS_LSB + 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gc_poll_scheduler_if.sv
// -----------------------------------------------------------------------------
// gc_poll_scheduler_if
// Bundles every non-clock/reset signal of gc_poll_scheduler.
//   slave  : the scheduler side (requests and report in, strobes/snapshot out)
//   master : the environment side (requesters, consumers, interface block)
// Signals: enable, req, rumble_req, ack (NREQ wide), Poll, Rumble,
//          rpt_in/snapshot (64), snap_valid, snap_changed, busy, overrun_cnt (8)
// -----------------------------------------------------------------------------
interface gc_poll_scheduler_if #(
   parameter int NREQ = 2
);
   logic            enable;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] rumble_req;
   logic [NREQ-1:0] ack;
   logic            Poll;
   logic            Rumble;
   logic [63:0]     rpt_in;
   logic [63:0]     snapshot;
   logic            snap_valid;
   logic            snap_changed;
   logic            busy;
   logic [7:0]      overrun_cnt;

   modport slave (
      input  enable, req, rumble_req, rpt_in,
      output ack, Poll, Rumble, snapshot, snap_valid, snap_changed, busy, overrun_cnt
   );

   modport master (
      output enable, req, rumble_req, rpt_in,
      input  ack, Poll, Rumble, snapshot, snap_valid, snap_changed, busy, overrun_cnt
   );
endinterface

// File: rtl/gc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gc_rr_arbiter
// Combinational round-robin pick. The search starts at ptr_i+1 (mod NREQ) and
// returns the first asserted request.
//   req_i   : request vector
//   ptr_i   : index of the last requester served
//   grant_o : one-hot grant (all zero when nothing is requested)
//   any_o   : some request was found
//   idx_o   : binary index of the granted requester
// -----------------------------------------------------------------------------
module gc_rr_arbiter
   import gc_ctrl_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic            any_o,
   output logic [IW-1:0]   idx_o
);

   int              cand;
   logic [NREQ-1:0] sel;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a value held over, which would otherwise infer a latch.
      grant_o = '0;
      any_o   = 1'b0;
      idx_o   = '0;
      cand    = 0;
      sel     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = (int'(ptr_i) + i) % NREQ;
         sel  = NREQ'(1) << cand;
         if (!any_o && ((req_i & sel) != '0)) begin
            any_o   = 1'b1;
            grant_o = sel;
            idx_o   = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/gc_poll_scheduler.sv
// -----------------------------------------------------------------------------
// gc_poll_scheduler
// Sequences the GameCube controller interface block: issues Poll on a fixed
// period or on demand, shares the controller among NREQ requesters round-robin,
// captures each 64-bit report into a stable snapshot and holds Rumble steady
// for the whole transaction.
//   usClock : 1 MHz clock
//   Reset   : synchronous active-high reset
//   bus     : gc_poll_scheduler_if.slave (enable, req, rumble_req, rpt_in in;
//             ack, Poll, Rumble, snapshot, snap_valid, snap_changed, busy,
//             overrun_cnt out)
// -----------------------------------------------------------------------------
module gc_poll_scheduler
   import gc_ctrl_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int PERIOD_US = PERIOD_60HZ_US,
   parameter int XFER_US   = XFER_DEFAULT_US,
   parameter int GAP_US    = GAP_DEFAULT_US,
   parameter int CW        = 16
) (
   input logic                usClock,
   input logic                Reset,
   gc_poll_scheduler_if.slave bus
);

   localparam int IW = idx_width(NREQ);

   sched_state_t    state_q;
   logic [CW-1:0]   per_cnt_q;
   logic [CW-1:0]   cnt_q;
   logic            pend_q;
   logic [7:0]      ovr_q;
   logic            poll_q;
   logic            rumble_q;
   logic            busy_q;
   logic            snap_valid_q;
   logic            snap_changed_q;
   logic [63:0]     snap_q;
   logic [NREQ-1:0] ack_q;
   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   owner_q;
   logic [NREQ-1:0] owner_grant_q;
   logic            owner_vld_q;

   logic [NREQ-1:0] arb_grant;
   logic            arb_any;
   logic [IW-1:0]   arb_idx;

   logic tick, xfer_done, gap_done, want, go_issue;

   gc_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .any_o   (arb_any),
      .idx_o   (arb_idx)
   );

   assign tick      = (per_cnt_q == CW'(PERIOD_US - 1));
   assign xfer_done = (cnt_q == CW'(XFER_US - 1));
   assign gap_done  = (cnt_q == CW'(GAP_US - 1));
   assign want      = bus.enable && (pend_q || (|bus.req));
   // The last GAP cycle doubles as the idle decision cycle, so exactly GAP_US
   // idle cycles separate CAPTURE from the next ISSUE.
   assign go_issue  = want && ((state_q == IDLE) || ((state_q == GAP) && gap_done));

   // Free-running period counter, independent of state and enable.
   always_ff @(posedge usClock) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      if (Reset)     per_cnt_q <= '0;
      else if (tick) per_cnt_q <= '0;
      else           per_cnt_q <= per_cnt_q + CW'(1);
   end

   // Pending auto-poll and lost-tick counter. A tick landing on the cycle that
   // enters ISSUE is absorbed by that transaction.
   always_ff @(posedge usClock) begin
      if (Reset) begin
         pend_q <= 1'b0;
         ovr_q  <= '0;
      end else if (go_issue) begin
         pend_q <= 1'b0;
      end else if (tick && bus.enable) begin
         pend_q <= 1'b1;
         if (pend_q && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
      end
   end

   // Transaction sequencer; all outputs registered. Pulse outputs default low.
   always_ff @(posedge usClock) begin
      if (Reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         poll_q         <= 1'b0;
         rumble_q       <= 1'b0;
         busy_q         <= 1'b0;
         snap_valid_q   <= 1'b0;
         snap_changed_q <= 1'b0;
         snap_q         <= '0;
         ack_q          <= '0;
         ptr_q          <= IW'(NREQ - 1);
         owner_q        <= '0;
         owner_grant_q  <= '0;
         owner_vld_q    <= 1'b0;
      end else begin
         poll_q         <= 1'b0;
         snap_valid_q   <= 1'b0;
         snap_changed_q <= 1'b0;
         ack_q          <= '0;
         if (go_issue) begin
            state_q       <= ISSUE;
            poll_q        <= 1'b1;
            busy_q        <= 1'b1;
            rumble_q      <= |bus.rumble_req;
            owner_q       <= arb_idx;
            owner_grant_q <= arb_grant;
            owner_vld_q   <= arb_any;
         end else begin
            case (state_q)
               IDLE: ;
               ISSUE: begin
                  state_q <= XFER;
                  cnt_q   <= '0;
               end
               XFER: begin
                  if (xfer_done) begin
                     state_q        <= CAPTURE;
                     snap_q         <= bus.rpt_in;
                     snap_valid_q   <= 1'b1;
                     snap_changed_q <= (bus.rpt_in != snap_q);
                     ack_q          <= owner_grant_q;
                     if (owner_vld_q) ptr_q <= owner_q;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               CAPTURE: begin
                  state_q <= GAP;
                  cnt_q   <= '0;
               end
               GAP: begin
                  if (gap_done) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.Poll         = poll_q;
   assign bus.Rumble       = rumble_q;
   assign bus.ack          = ack_q;
   assign bus.snapshot     = snap_q;
   assign bus.snap_valid   = snap_valid_q;
   assign bus.snap_changed = snap_changed_q;
   assign bus.busy         = busy_q;
   assign bus.overrun_cnt  = ovr_q;

endmodule
